// File: rtl/exec_seq_ctrl_if.sv
// Port bundle for exec_seq_ctrl: IR/branch feedback in, memory handshake and
// datapath control strobes out. The sequencer uses the master side.
interface exec_seq_ctrl_if;
   logic [31:0] instr;
   logic        BrEq;
   logic        BrLT;
   logic        mem_ready;
   logic        ASel;
   logic        BSel;
   logic        BrUn;
   logic [4:0]  alu_ctrl;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        ir_we;
   logic        pc_we;
   logic        pc_sel;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic        halted;
   logic        illegal;
   logic        bus_err;
   logic [31:0] instret;

   modport master (
      input  instr, BrEq, BrLT, mem_ready,
      output ASel, BSel, BrUn, alu_ctrl, mem_req, mem_we, addr_sel, ir_we,
             pc_we, pc_sel, reg_we, wb_sel, halted, illegal, bus_err, instret
   );

   modport slave (
      output instr, BrEq, BrLT, mem_ready,
      input  ASel, BSel, BrUn, alu_ctrl, mem_req, mem_we, addr_sel, ir_we,
             pc_we, pc_sel, reg_we, wb_sel, halted, illegal, bus_err, instret
   );
endinterface

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the execute datapath
// over a single shared memory port, with retire counting and sticky fault flags.
module exec_seq_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   exec_seq_ctrl_if.master bus
);
   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_PASS_B = 5'd10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // SUB only exists for register-register ops; funct7b5 on I-type selects SRAI only
   function automatic logic [4:0] alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                                 input logic is_reg);
      logic [4:0] alu;
      case (f3)
         3'b000:  alu = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu = ALU_SLL;
         3'b010:  alu = ALU_SLT;
         3'b011:  alu = ALU_SLTU;
         3'b100:  alu = ALU_XOR;
         3'b101:  alu = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu = ALU_OR;
         3'b111:  alu = ALU_AND;
         default: alu = ALU_ADD;
      endcase
      return alu;
   endfunction

   // Returns {ASel, BSel, alu_ctrl} for the instruction class
   function automatic logic [6:0] alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                             input logic f7b5);
      logic       asel;
      logic       bsel;
      logic [4:0] alu;
      asel = 1'b0;
      bsel = 1'b0;
      alu  = ALU_ADD;
      case (op)
         OP_R:                        alu = alu_from_funct(f3, f7b5, 1'b1);
         OP_I: begin
            bsel = 1'b1;
            alu  = alu_from_funct(f3, f7b5, 1'b0);
         end
         OP_LOAD, OP_STORE, OP_JALR:  bsel = 1'b1;
         OP_LUI: begin
            bsel = 1'b1;
            alu  = ALU_PASS_B;
         end
         OP_AUIPC, OP_JAL, OP_BRANCH: begin
            asel = 1'b1;
            bsel = 1'b1;
         end
         default:                     alu = ALU_ADD;
      endcase
      return {asel, bsel, alu};
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
      logic taken;
      case (f3)
         3'b000:          taken = eq;
         3'b001:          taken = !eq;
         3'b100, 3'b110:  taken = lt;
         3'b101, 3'b111:  taken = !lt;
         default:         taken = 1'b0;
      endcase
      return taken;
   endfunction

   function automatic logic opcode_legal(input logic [6:0] op);
      logic legal;
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: legal = 1'b1;
         default:                                      legal = 1'b0;
      endcase
      return legal;
   endfunction

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_wait;
   logic [31:0]       r_instret;
   logic              r_halted;
   logic              r_illegal;
   logic              r_bus_err;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_funct7b5;
   logic [6:0] w_alu_bundle;
   logic       w_timeout;
   logic       w_waiting;
   logic       w_unused_instr;

   logic       w_asel, w_bsel, w_brun;
   logic [4:0] w_alu_ctrl;
   logic       w_mem_req, w_mem_we, w_addr_sel, w_ir_we;
   logic       w_pc_we, w_pc_sel, w_reg_we;
   logic [1:0] w_wb_sel;
   logic       w_retire, w_set_halted, w_set_illegal, w_set_bus_err;

   assign w_opcode       = bus.instr[6:0];
   assign w_funct3       = bus.instr[14:12];
   assign w_funct7b5     = bus.instr[30];
   assign w_unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
   assign w_alu_bundle   = alu_decode(w_opcode, w_funct3, w_funct7b5);
   assign w_timeout      = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LIMIT) && !bus.mem_ready;
   assign w_waiting      = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;

   // Next-state and control decode
   always_comb begin
      w_next        = r_state;
      w_asel        = 1'b0;
      w_bsel        = 1'b0;
      w_brun        = 1'b0;
      w_alu_ctrl    = ALU_ADD;
      w_mem_req     = 1'b0;
      w_mem_we      = 1'b0;
      w_addr_sel    = 1'b0;
      w_ir_we       = 1'b0;
      w_pc_we       = 1'b0;
      w_pc_sel      = 1'b0;
      w_reg_we      = 1'b0;
      w_wb_sel      = 2'd0;
      w_retire      = 1'b0;
      w_set_halted  = 1'b0;
      w_set_illegal = 1'b0;
      w_set_bus_err = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (bus.mem_ready) begin
               w_ir_we = 1'b1;
               w_next  = S_DECODE;
            end else if (w_timeout) begin
               w_set_bus_err = 1'b1;
               w_next        = S_HALT;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            if (opcode_legal(w_opcode)) begin
               w_next = S_EXEC;
            end else begin
               w_set_illegal = 1'b1;
               w_next        = S_HALT;
            end
         end
         S_EXEC: begin
            {w_asel, w_bsel, w_alu_ctrl} = w_alu_bundle;
            case (w_opcode)
               OP_BRANCH: begin
                  w_brun   = w_funct3[1];
                  w_pc_we  = 1'b1;
                  w_pc_sel = branch_taken(w_funct3, bus.BrEq, bus.BrLT);
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end
               OP_LOAD, OP_STORE: w_next = S_MEM;
               OP_SYSTEM: begin
                  w_retire     = 1'b1;
                  w_set_halted = 1'b1;
                  w_next       = S_HALT;
               end
               default: w_next = S_WB;
            endcase
         end
         S_MEM: begin
            {w_asel, w_bsel, w_alu_ctrl} = w_alu_bundle;
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            w_mem_we   = (w_opcode == OP_STORE);
            if (bus.mem_ready) begin
               if (w_opcode == OP_STORE) begin
                  w_pc_we  = 1'b1;
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end else if (w_timeout) begin
               w_set_bus_err = 1'b1;
               w_next        = S_HALT;
            end else begin
               w_next = S_MEM;
            end
         end
         S_WB: begin
            {w_asel, w_bsel, w_alu_ctrl} = w_alu_bundle;
            w_reg_we = 1'b1;
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
            if ((w_opcode == OP_JAL) || (w_opcode == OP_JALR)) begin
               w_wb_sel = 2'd2;
               w_pc_sel = 1'b1;
            end else if (w_opcode == OP_LOAD) begin
               w_wb_sel = 2'd1;
            end else begin
               w_wb_sel = 2'd0;
            end
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_HALT;
      endcase
   end

   // State, wait counter, retire counter and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_wait    <= '0;
         r_instret <= 32'd0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_wait <= '0;
         end else if (w_waiting) begin
            r_wait <= r_wait + WAIT_W'(1);
         end else begin
            r_wait <= r_wait;
         end
         if (w_retire) begin
            r_instret <= r_instret + 32'd1;
         end
         if (w_set_halted) begin
            r_halted <= 1'b1;
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
         if (w_set_bus_err) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   // Memory-side strobes are gated by reset so an in-flight access is dropped at once
   assign bus.mem_req  = w_mem_req & rst_n;
   assign bus.mem_we   = w_mem_we & rst_n;
   assign bus.ir_we    = w_ir_we & rst_n;
   assign bus.addr_sel = w_addr_sel;
   assign bus.ASel     = w_asel;
   assign bus.BSel     = w_bsel;
   assign bus.BrUn     = w_brun;
   assign bus.alu_ctrl = w_alu_ctrl;
   assign bus.pc_we    = w_pc_we;
   assign bus.pc_sel   = w_pc_sel;
   assign bus.reg_we   = w_reg_we;
   assign bus.wb_sel   = w_wb_sel;
   assign bus.halted   = r_halted;
   assign bus.illegal  = r_illegal;
   assign bus.bus_err  = r_bus_err;
   assign bus.instret  = r_instret;
endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed bench for exec_seq_ctrl (MEM_TIMEOUT=4): per-cycle control vectors,
// retire counting, sticky flags, timeout and reset behaviour.
module tb_exec_seq_ctrl;
   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   exec_seq_ctrl_if bus ();

   exec_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ASel,BSel,BrUn,alu_ctrl,mem_req,mem_we,addr_sel,ir_we,pc_we,pc_sel,reg_we,wb_sel}
   function automatic logic [16:0] ctl_obs();
      return {bus.ASel, bus.BSel, bus.BrUn, bus.alu_ctrl, bus.mem_req, bus.mem_we,
              bus.addr_sel, bus.ir_we, bus.pc_we, bus.pc_sel, bus.reg_we, bus.wb_sel};
   endfunction

   function automatic logic [16:0] mk(input logic asel, input logic bsel, input logic brun,
                                      input logic [4:0] alu, input logic req, input logic we,
                                      input logic asl, input logic ir, input logic pcwe,
                                      input logic pcsel, input logic regwe,
                                      input logic [1:0] wbs);
      return {asel, bsel, brun, alu, req, we, asl, ir, pcwe, pcsel, regwe, wbs};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rdy);
      @(negedge clk);
      bus.mem_ready = rdy;
      #1;
   endtask

   // FETCH with zero wait, then DECODE; checks retire count seen during FETCH
   task automatic fetch_dec(input logic [31:0] ins, input string tag, input logic [31:0] exp_ir);
      @(negedge clk);
      bus.instr     = ins;
      bus.mem_ready = 1'b1;
      #1;
      chk({tag, "_fetch"}, 32'(ctl_obs()), 32'(mk(0,0,0,5'd0, 1,0,0,1, 0,0,0,2'd0)));
      chk({tag, "_instret"}, bus.instret, exp_ir);
      step(1'b1);
      chk({tag, "_decode"}, 32'(ctl_obs()), 32'd0);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst_n         = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
      chk("rel_fetch", 32'(ctl_obs()), 32'(mk(0,0,0,5'd0, 1,0,0,0, 0,0,0,2'd0)));
      chk("rel_flags", 32'({bus.halted, bus.illegal, bus.bus_err}), 32'd0);
   endtask

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.instr     = 32'd0;
      bus.BrEq      = 1'b0;
      bus.BrLT      = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_ctl", 32'(ctl_obs()), 32'd0);
      chk("rst_instret", bus.instret, 32'd0);
      chk("rst_flags", 32'({bus.halted, bus.illegal, bus.bus_err}), 32'd0);
      release_rst();

      fetch_dec(32'h002081B3, "add", 32'd0);
      step(1'b1); chk("add_exec", 32'(ctl_obs()), 32'(mk(0,0,0,5'd0, 0,0,0,0, 0,0,0,2'd0)));
      step(1'b1); chk("add_wb", 32'(ctl_obs()), 32'(mk(0,0,0,5'd0, 0,0,0,0, 1,0,1,2'd0)));

      bus.BrLT = 1'b1;
      fetch_dec(32'h00006063, "bltu", 32'd1);
      step(1'b1); chk("bltu_exec", 32'(ctl_obs()), 32'(mk(1,1,1,5'd0, 0,0,0,0, 1,1,0,2'd0)));
      fetch_dec(32'h00005063, "bge", 32'd2);
      step(1'b1); chk("bge_exec", 32'(ctl_obs()), 32'(mk(1,1,0,5'd0, 0,0,0,0, 1,0,0,2'd0)));
      bus.BrLT = 1'b0;

      fetch_dec(32'h0000A083, "lw", 32'd3);
      step(1'b0); chk("lw_exec", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 0,0,0,0, 0,0,0,2'd0)));
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         chk("lw_mem_wait", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 1,0,1,0, 0,0,0,2'd0)));
      end
      step(1'b1); chk("lw_mem_done", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 1,0,1,0, 0,0,0,2'd0)));
      step(1'b1); chk("lw_wb", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 0,0,0,0, 1,0,1,2'd1)));

      fetch_dec(32'h0020A023, "sw", 32'd4);
      step(1'b1); chk("sw_exec", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 0,0,0,0, 0,0,0,2'd0)));
      step(1'b1); chk("sw_mem", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 1,1,1,0, 1,0,0,2'd0)));

      fetch_dec(32'h40005013, "srai", 32'd5);
      step(1'b1); chk("srai_exec", 32'(ctl_obs()), 32'(mk(0,1,0,5'd7, 0,0,0,0, 0,0,0,2'd0)));
      step(1'b1); chk("srai_wb", 32'(ctl_obs()), 32'(mk(0,1,0,5'd7, 0,0,0,0, 1,0,1,2'd0)));

      fetch_dec(32'h40000013, "addi_b30", 32'd6);
      step(1'b1); chk("addi_exec", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 0,0,0,0, 0,0,0,2'd0)));
      step(1'b1); chk("addi_wb", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 0,0,0,0, 1,0,1,2'd0)));

      fetch_dec(32'h40000033, "sub", 32'd7);
      step(1'b1); chk("sub_exec", 32'(ctl_obs()), 32'(mk(0,0,0,5'd1, 0,0,0,0, 0,0,0,2'd0)));
      step(1'b1); chk("sub_wb", 32'(ctl_obs()), 32'(mk(0,0,0,5'd1, 0,0,0,0, 1,0,1,2'd0)));

      fetch_dec(32'h000000B7, "lui", 32'd8);
      step(1'b1); chk("lui_exec", 32'(ctl_obs()), 32'(mk(0,1,0,5'd10, 0,0,0,0, 0,0,0,2'd0)));
      step(1'b1); chk("lui_wb", 32'(ctl_obs()), 32'(mk(0,1,0,5'd10, 0,0,0,0, 1,0,1,2'd0)));

      fetch_dec(32'h0000006F, "jal", 32'd9);
      step(1'b1); chk("jal_exec", 32'(ctl_obs()), 32'(mk(1,1,0,5'd0, 0,0,0,0, 0,0,0,2'd0)));
      step(1'b1); chk("jal_wb", 32'(ctl_obs()), 32'(mk(1,1,0,5'd0, 0,0,0,0, 1,1,1,2'd2)));

      fetch_dec(32'h00008067, "jalr", 32'd10);
      step(1'b1); chk("jalr_exec", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 0,0,0,0, 0,0,0,2'd0)));
      step(1'b1); chk("jalr_wb", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 0,0,0,0, 1,1,1,2'd2)));

      fetch_dec(32'h0000007F, "illegal", 32'd11);
      for (int i = 0; i < 2; i++) begin
         step(1'b1);
         chk("ill_halt_ctl", 32'(ctl_obs()), 32'd0);
         chk("ill_flags", 32'({bus.halted, bus.illegal, bus.bus_err}), 32'b010);
         chk("ill_instret", bus.instret, 32'd11);
      end

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst2_instret", bus.instret, 32'd0);
      chk("rst2_flags", 32'({bus.halted, bus.illegal, bus.bus_err}), 32'd0);
      release_rst();

      fetch_dec(32'h00000073, "ecall", 32'd0);
      step(1'b1); chk("ecall_exec", 32'(ctl_obs()), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1);
         chk("ecall_halt_ctl", 32'(ctl_obs()), 32'd0);
         chk("ecall_flags", 32'({bus.halted, bus.illegal, bus.bus_err}), 32'b100);
         chk("ecall_instret", bus.instret, 32'd1);
      end

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      release_rst();
      fetch_dec(32'h002081B3, "add2", 32'd0);
      step(1'b1);
      step(1'b1); chk("add2_wb", 32'(ctl_obs()), 32'(mk(0,0,0,5'd0, 0,0,0,0, 1,0,1,2'd0)));
      fetch_dec(32'h0000A083, "lw2", 32'd1);
      step(1'b0);
      step(1'b0); chk("lw2_mem", 32'(ctl_obs()), 32'(mk(0,1,0,5'd0, 1,0,1,0, 0,0,0,2'd0)));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
      chk("mid_rst_ctl", 32'(ctl_obs()), 32'd0);
      chk("mid_rst_instret", bus.instret, 32'd0);

      release_rst();
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         chk("to_fetch_wait", 32'(ctl_obs()), 32'(mk(0,0,0,5'd0, 1,0,0,0, 0,0,0,2'd0)));
         chk("to_no_err_yet", 32'(bus.bus_err), 32'd0);
      end
      step(1'b0);
      chk("to_halt_ctl", 32'(ctl_obs()), 32'd0);
      chk("to_flags", 32'({bus.halted, bus.illegal, bus.bus_err}), 32'b001);
      step(1'b1);
      chk("to_halt_absorb", 32'(ctl_obs()), 32'd0);
      chk("to_instret", bus.instret, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/exec_seq_ctrl.md
# exec_seq_ctrl

Multi-cycle sequencer for the execute datapath: drives ASel, BSel, BrUn and alu_ctrl of the execute stage. It also drives the PC, IR, register-file and memory enables, so the single-cycle datapath runs as a FETCH/DECODE/EXEC/MEM/WB machine over one shared memory port. It sits between the instruction register and the execute, memory and writeback muxes, and consumes BrEq/BrLT back from the execute stage.

## Interface
- MEM_TIMEOUT, 16: max wait cycles for mem_ready per access; 0 disables the timeout.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  current IR contents; opcode [6:0], funct3 [14:12], funct7b5 [30].
- BrEq  in  1  branch comparator equal.
- BrLT  in  1  branch comparator less-than (signed/unsigned per BrUn).
- mem_ready  in  1  memory completes the current request this cycle.
- ASel  out  1  0 = Data_A, 1 = pc_addr.
- BSel  out  1  0 = Data_B, 1 = imm_out.
- BrUn  out  1  unsigned compare select.
- alu_ctrl  out  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- mem_req  out  1  memory request valid.
- mem_we  out  1  store.
- addr_sel  out  1  0 = PC to memory address, 1 = alu_result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_sel  out  1  0 = PC+4, 1 = alu_result with bit 0 cleared.
- reg_we  out  1  register-file write.
- wb_sel  out  2  0 ALU, 1 memory data, 2 PC+4.
- halted  out  1  sticky: ECALL/EBREAK retired.
- illegal  out  1  sticky: unsupported opcode.
- bus_err  out  1  sticky: memory timeout.
- instret  out  32  retired-instruction count; wraps.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are combinational from the state and instr. Every unlisted output is 0.
- FETCH:
  - Drives mem_req=1, addr_sel=0.
  - When mem_ready=1: ir_we=1 that cycle, then go to DECODE.
- DECODE: one cycle for register-file read, then EXEC. Opcode classes:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
  - Any other opcode: go to HALT and set illegal.
- EXEC:
  - R: ASel=0, BSel=0, alu_ctrl from {funct7b5, funct3}.
  - I: BSel=1. funct7b5 is used only for shifts (SRAI); ADDI maps to ADD, never SUB.
  - LOAD/STORE: ADD with BSel=1, then go to MEM.
  - LUI: PASS_B with BSel=1.
  - AUIPC, JAL: ASel=1, BSel=1, ADD.
  - JALR: ASel=0, BSel=1, ADD.
  - BRANCH: BrUn = funct3[1]. taken = BEQ:BrEq, BNE:!BrEq, BLT/BLTU:BrLT, BGE/BGEU:!BrLT. ALU computes PC+imm (ASel=1, BSel=1). pc_we=1, pc_sel=taken, instret++, then FETCH.
  - SYSTEM: instret++, set halted, then HALT.
  - All other classes go to WB.
- MEM:
  - Drives mem_req=1, addr_sel=1, mem_we = STORE, and holds the EXEC ALU controls.
  - On mem_ready, STORE: pc_we=1, pc_sel=0, instret++, then FETCH.
  - On mem_ready, LOAD: go to WB.
- WB:
  - reg_we=1, pc_we=1, instret++, then FETCH.
  - wb_sel = 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel = 1 for JAL/JALR, 0 otherwise. ALU controls stay held so alu_result is stable.
- HALT: absorbing; all enables 0. Only reset exits.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0.
  - If the counter reaches MEM_TIMEOUT-1 while mem_ready=0, next state is HALT with bus_err set.
  - mem_ready=1 on the limit cycle takes priority over the timeout.

## Timing
- Reset: state=FETCH, instret=0, sticky flags=0, wait counter=0. Outputs follow the state combinationally, so mem_req=1 on the first cycle after rst_n rises.
- Reset mid-access drops mem_req asynchronously; the transaction is abandoned.
- Cycle counts with zero-wait memory (mem_ready high on the first request cycle):
  - Branch: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle adds 1 cycle.
- Request handshake: mem_req, mem_we and addr_sel stay stable until the cycle in which mem_ready=1. mem_ready sampled outside FETCH/MEM is ignored.
- instret increments exactly once per retired instruction, on the retiring edge. 0xFFFFFFFF wraps to 0.

## Test plan
- ADD x3,x1,x2 (instr 0x002081B3), mem_ready=1 -> 4 cycles. EXEC shows alu_ctrl=0, ASel=0, BSel=0. WB shows reg_we=1, wb_sel=0, pc_we=1, pc_sel=0. instret 0->1.
- BLTU (funct3=110) with BrLT=1 -> EXEC has BrUn=1, pc_we=1, pc_sel=1, 3 cycles total. Repeat with BGE (funct3=101), BrLT=1 -> pc_sel=0, BrUn=0.
- LW with mem_ready low for 3 MEM cycles -> mem_req, addr_sel=1 held, mem_we=0. WB has wb_sel=1, 8 cycles total.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> HALT after 4 FETCH cycles, bus_err=1, all enables 0 thereafter.
- Opcode 0x7F -> illegal=1, HALT, instret unchanged. ECALL 0x00000073 -> halted=1, instret+1.
- Assert rst_n=0 during a MEM wait -> mem_req drops immediately. After release: state FETCH, instret=0, flags cleared.
